dma_state_seq: RTL
==================

DMA_STATE_SEQ -- requirements
Module: dma_state_seq

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  leave idle; sampled only while dmpst==0.
REQ-004 mack  input  1  memory acknowledge; sampled only while mreq==1.
REQ-005 dmnst_b  input  4  active-low next-state code from the decode stage.
REQ-006 adctlp_b  input  3  active-low address-control code from the decode stage.
REQ-007 xlen, ylen  input  8 each  inclusive X/Y terminal counts; static while mreq==1.
REQ-008 dmpst  output  4  registered present state, fed back to the decode stage.
REQ-009 xskip, yskip  output  1 each  combinational: xcnt==xlen, ycnt==ylen.
REQ-010 page  output  1  registered page bit.
REQ-011 xcnt, ycnt  output  8 each  registered address counters.
REQ-012 mreq  output  1  combinational: dmpst!=0.
REQ-013 err  output  1  sticky illegal-state flag; present only under the configuration macro (REQ-026).

Function
REQ-014 adv = (dmpst==0) ? start : mack; all registers hold when adv==0.
REQ-015 On adv: dmpst <= ~dmnst_b; op = ~adctlp_b executes in the same edge.
REQ-016 Latency: new dmpst, counters and page visible one clk after the adv edge; xskip/yskip follow the new counters with zero added latency.
REQ-017 op 0, 7: hold counters and page.
REQ-018 op 1 (incr X): xcnt <= (xcnt==xlen) ? 0 : xcnt+1.
REQ-019 op 2 (incr Y): xcnt <= 0; ycnt <= (ycnt==ylen) ? 0 : ycnt+1.
REQ-020 op 3 (load): xcnt <= 0; ycnt <= 0; page unchanged.
REQ-021 op 4 (decr X): xcnt <= (xcnt==0) ? xlen : xcnt-1.
REQ-022 op 5 (clear): xcnt, ycnt, page all <= 0.
REQ-023 op 6: page <= ~page; counters hold.
REQ-024 Arithmetic: all counter arithmetic is 8-bit; wrap happens only through the REQ-018/019/021 terminal rules; xlen==0 keeps xcnt at 0.
REQ-025 Boundaries:
- mack while dmpst==0: ignored.
- start while dmpst!=0: ignored.
- start and mack both high: adv follows REQ-014 only.

Configuration
REQ-026 DMA_SEQ_ILLEGAL_TRAP_EN defined:
- ~dmnst_b==4'hF on adv loads dmpst <= 0 instead of 4'hF, and sets err <= 1.
- err clears only on reset.
- counter op still executes.
REQ-027 DMA_SEQ_ILLEGAL_TRAP_EN undefined:
- 4'hF loads like any other code.
- err port is omitted.

Reset
REQ-028 reset==1 forces immediately, independent of clk: dmpst=0, xcnt=0, ycnt=0, page=0, err=0.
- Hence mreq=0 during reset.
REQ-029 Reset asserted mid-transfer (mreq==1) abandons the transfer; the first adv after release requires start.
REQ-030 Deassertion is synchronised externally; no start is honoured in the cycle where reset is high.

Verification
REQ-031 Idle hold: reset, dmpst=0, start=0, mack=1 for 5 cycles -> dmpst stays 0, mreq=0, counters 0.
REQ-032 Start: start=1, dmnst_b=4'b1101, adctlp_b=3'b100 (op 3) -> next cycle dmpst=2, mreq=1, xcnt=ycnt=0.
REQ-033 X wrap: xlen=2, ylen=1, op 1 with mack each cycle -> xcnt 1,2,0; xskip=1 only when xcnt==2.
REQ-034 Y then page: op 2 at ycnt=1, ylen=1 -> ycnt=0, xcnt=0; then op 6 -> page toggles 0->1; mack=0 cycles hold all values.
REQ-035 Illegal state: dmnst_b=4'b0000 on adv -> with DMA_SEQ_ILLEGAL_TRAP_EN: dmpst=0, err=1 until reset; without it: dmpst=4'hF.
REQ-036 Async reset: assert reset mid-cycle while dmpst=5, xcnt=7 -> all outputs 0 before the next clk edge; mack after release is ignored.

Source files
------------

// File: rtl/dma_state_seq.sv
// dma_state_seq: present-state register and X/Y/page address counters for a DMA sequencer.
// Optional trap of next-state code 4'hF into idle with a sticky err_o: DMA_SEQ_ILLEGAL_TRAP_EN.
module dma_state_seq (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mack_i,
  input  logic [3:0] dmnst_b_i,
  input  logic [2:0] adctlp_b_i,
  input  logic [7:0] xlen_i,
  input  logic [7:0] ylen_i,
  output logic [3:0] dmpst_o,
  output logic       xskip_o,
  output logic       yskip_o,
  output logic       page_o,
  output logic [7:0] xcnt_o,
  output logic [7:0] ycnt_o,
  output logic       mreq_o
`ifdef DMA_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic       err_o
`endif
);

  typedef enum logic [2:0] {
    OP_HOLD0 = 3'd0,
    OP_INCX  = 3'd1,
    OP_INCY  = 3'd2,
    OP_LOAD  = 3'd3,
    OP_DECX  = 3'd4,
    OP_CLR   = 3'd5,
    OP_PAGE  = 3'd6,
    OP_HOLD7 = 3'd7
  } op_e;

  logic [3:0] dmpst_q, dmpst_d;
  logic [7:0] xcnt_q, xcnt_d;
  logic [7:0] ycnt_q, ycnt_d;
  logic       page_q, page_d;
  logic       adv;
  logic       idle;
  logic       x_term;
  logic       y_term;
  op_e        op;

  assign idle   = (dmpst_q == 4'h0);
  assign adv    = idle ? start_i : mack_i;
  assign op     = op_e'(~adctlp_b_i);
  assign x_term = (xcnt_q == xlen_i);
  assign y_term = (ycnt_q == ylen_i);

`ifdef DMA_SEQ_ILLEGAL_TRAP_EN
  logic err_q, err_d;
`endif

  always_comb begin
    dmpst_d = dmpst_q;
    xcnt_d  = xcnt_q;
    ycnt_d  = ycnt_q;
    page_d  = page_q;
`ifdef DMA_SEQ_ILLEGAL_TRAP_EN
    err_d   = err_q;
`endif
    if (adv) begin
      dmpst_d = ~dmnst_b_i;
`ifdef DMA_SEQ_ILLEGAL_TRAP_EN
      // All-zero active-low code decodes to 4'hF: park in idle and flag it.
      if (dmnst_b_i == 4'h0) begin
        dmpst_d = 4'h0;
        err_d   = 1'b1;
      end
`endif
      case (op)
        OP_INCX: xcnt_d = x_term ? 8'd0 : xcnt_q + 8'd1;
        OP_INCY: begin
          xcnt_d = 8'd0;
          ycnt_d = y_term ? 8'd0 : ycnt_q + 8'd1;
        end
        OP_LOAD: begin
          xcnt_d = 8'd0;
          ycnt_d = 8'd0;
        end
        OP_DECX: xcnt_d = (xcnt_q == 8'd0) ? xlen_i : xcnt_q - 8'd1;
        OP_CLR: begin
          xcnt_d = 8'd0;
          ycnt_d = 8'd0;
          page_d = 1'b0;
        end
        OP_PAGE: page_d = ~page_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dmpst_q <= 4'h0;
      xcnt_q  <= 8'd0;
      ycnt_q  <= 8'd0;
      page_q  <= 1'b0;
    end else begin
      dmpst_q <= dmpst_d;
      xcnt_q  <= xcnt_d;
      ycnt_q  <= ycnt_d;
      page_q  <= page_d;
    end
  end

`ifdef DMA_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  assign err_o = err_q;
`endif

  assign dmpst_o = dmpst_q;
  assign xcnt_o  = xcnt_q;
  assign ycnt_o  = ycnt_q;
  assign page_o  = page_q;
  assign xskip_o = x_term;
  assign yskip_o = y_term;
  assign mreq_o  = ~idle;

endmodule
